// File: rtl/count_chk_pkg.sv
//------------------------------------------------------------------------------
// count_chk_pkg
//   Shared types, default constants and the next-count reference function used
//   by count_range_checker and count_range_model.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package count_chk_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_e;

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_MIN   = 10;
   localparam int unsigned DEF_MAX   = 40;

   // Operands are zero-extended to 32 bits. c+1 is only taken below max_v and
   // c-1 only above min_v, so the result never leaves the caller's width.
   function automatic logic [31:0] next_count(
      input logic [31:0] c,
      input logic        cnt_rst,
      input logic        load,
      input logic [31:0] data,
      input logic        u_d,
      input logic [31:0] min_v,
      input logic [31:0] max_v
   );
      logic [31:0] n;
      if (!cnt_rst || (c > max_v) || (c < min_v))
         n = min_v;
      else if (load)
         n = data;
      else if (u_d)
         n = (c >= max_v) ? min_v : c + 32'd1;
      else
         n = (c <= min_v) ? max_v : c - 32'd1;
      return n;
   endfunction

endpackage

`default_nettype wire

// File: rtl/count_range_model.sv
//------------------------------------------------------------------------------
// count_range_model
//   Combinational next-count predictor for the MIN..MAX up/down counter.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module count_range_model
   import count_chk_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned MIN   = DEF_MIN,
   parameter int unsigned MAX   = DEF_MAX
) (
   input  logic [WIDTH-1:0] count,
   input  logic             cnt_rst,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic             u_d,
   output logic [WIDTH-1:0] next
);

   logic [31:0] next_wide;
   logic        unused_next_hi;

   assign next_wide      = next_count(32'(count), cnt_rst, load, 32'(data), u_d,
                                      32'(MIN), 32'(MAX));
   assign next           = next_wide[WIDTH-1:0];
   assign unused_next_hi = ^next_wide;

endmodule

`default_nettype wire

// File: rtl/count_range_checker.sv
//------------------------------------------------------------------------------
// count_range_checker
//   Passive monitor that predicts the range counter's next value, locks after
//   LOCK_CNT consecutive matches and flags mismatches while locked.
//   Optional: COUNT_RANGE_CHECKER_ERRCNT_EN enables the saturating err_count.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module count_range_checker
   import count_chk_pkg::*;
#(
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned MIN      = DEF_MIN,
   parameter int unsigned MAX      = DEF_MAX,
   parameter int unsigned LOCK_CNT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cnt_rst,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic             u_d,
   input  logic [WIDTH-1:0] count_in,
   output logic             locked,
   output logic             err,
   output logic [WIDTH-1:0] expected,
   output logic [7:0]       err_count
);

   localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pred_q, pred_d;
   logic [3:0]       match_cnt_q, match_cnt_d;
   logic [3:0]       match_inc;
   logic             err_q, err_d;
   logic             match;

   count_range_model #(
      .WIDTH (WIDTH),
      .MIN   (MIN),
      .MAX   (MAX)
   ) u_model (
      .count   (count_in),
      .cnt_rst (cnt_rst),
      .load    (load),
      .data    (data),
      .u_d     (u_d),
      .next    (pred_d)
   );

   assign match     = (count_in == pred_q);
   assign match_inc = match_cnt_q + 4'd1;

   always_comb begin
      state_d     = state_q;
      match_cnt_d = match_cnt_q;
      err_d       = 1'b0;
      case (state_q)
         IDLE: begin
            // Prediction is not valid yet: skip the compare this edge.
            state_d = ACQUIRE;
         end
         ACQUIRE: begin
            if (match) begin
               match_cnt_d = match_inc;
               if (match_inc == LOCK_TGT)
                  state_d = LOCKED;
            end else begin
               match_cnt_d = 4'd0;
            end
         end
         LOCKED: begin
            if (!match) begin
               err_d       = 1'b1;
               match_cnt_d = 4'd0;
               state_d     = ACQUIRE;
            end
         end
         default: begin
            state_d     = IDLE;
            match_cnt_d = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         pred_q      <= WIDTH'(MIN);
         match_cnt_q <= 4'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pred_q      <= pred_d;
         match_cnt_q <= match_cnt_d;
         err_q       <= err_d;
      end
   end

   assign locked   = (state_q == LOCKED);
   assign err      = err_q;
   assign expected = pred_q;

`ifdef COUNT_RANGE_CHECKER_ERRCNT_EN
   logic [7:0] err_count_q, err_count_d;

   always_comb begin
      err_count_d = err_count_q;
      if (err_d && (err_count_q != 8'hFF))
         err_count_d = err_count_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst)
         err_count_q <= 8'd0;
      else
         err_count_q <= err_count_d;
   end

   assign err_count = err_count_q;
`else
   assign err_count = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_count_range_checker.sv
//------------------------------------------------------------------------------
// tb_count_range_checker
//   Self-checking bench: emulated range counter drives the checker, a
//   behavioural model predicts locked/err/expected/err_count every cycle.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_count_range_checker;

   localparam int MIN  = 10;
   localparam int MAX  = 40;
   localparam int LOCK = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cnt_rst = 1'b1;
   logic       load = 1'b0;
   logic [7:0] data = 8'd0;
   logic       u_d = 1'b1;
   logic [7:0] count_in = 8'd10;
   logic       locked, err;
   logic [7:0] expected, err_count;

   int n_vec  = 0;
   int n_fail = 0;

   // emulated counter value and reference-model state
   int ctr      = MIN;
   int m_pred   = MIN;
   bit m_valid  = 0;
   bit m_locked = 0;
   bit m_err    = 0;
   int m_streak = 0;
   int m_errcnt = 0;

   count_range_checker #(
      .WIDTH    (8),
      .MIN      (MIN),
      .MAX      (MAX),
      .LOCK_CNT (LOCK)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cnt_rst   (cnt_rst),
      .load      (load),
      .data      (data),
      .u_d       (u_d),
      .count_in  (count_in),
      .locked    (locked),
      .err       (err),
      .expected  (expected),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   function automatic int f_ref(int c, bit cr, bit ld, int d, bit ud);
      if (!cr || c > MAX || c < MIN) return MIN;
      if (ld) return d;
      if (ud) return (c >= MAX) ? MIN : c + 1;
      return (c <= MIN) ? MAX : c - 1;
   endfunction

   // One clock edge: advance model and counter from the values present now.
   task automatic step();
      int seen = int'(count_in);
      if (!rst) begin
         m_valid = 0; m_locked = 0; m_err = 0; m_streak = 0; m_errcnt = 0;
         m_pred = MIN;
      end else begin
         if (!m_valid) begin
            m_valid = 1;
            m_err   = 0;
         end else if (m_locked) begin
            m_err = (seen != m_pred);
            if (m_err) begin
               m_locked = 0;
               m_streak = 0;
`ifdef COUNT_RANGE_CHECKER_ERRCNT_EN
               if (m_errcnt < 255) m_errcnt++;
`endif
            end
         end else begin
            m_err = 0;
            if (seen == m_pred) begin
               m_streak++;
               if (m_streak == LOCK) m_locked = 1;
            end else begin
               m_streak = 0;
            end
         end
         m_pred = f_ref(seen, cnt_rst, load, int'(data), u_d);
      end
      ctr = f_ref(ctr, cnt_rst, load, int'(data), u_d);
      @(posedge clk);
      #1;
      count_in = 8'(ctr);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step();
      step();
      if (locked !== 1'b0 || err !== 1'b0 || expected !== 8'd10 || err_count !== 8'd0) begin
         n_fail++;
         $display("FAIL reset got locked=%b err=%b expected=%0d err_count=%0d want 0 0 10 0",
                  locked, err, expected, err_count);
      end
      n_vec++;
   endtask

   task automatic test_up_count();
      rst = 1'b1; u_d = 1'b1; ctr = MIN; count_in = 8'(MIN);
      for (int i = 1; i <= 40; i++) begin
         step();
         if ({locked, err, expected, err_count} !== {m_locked, m_err, 8'(m_pred), 8'(m_errcnt)}) begin
            n_fail++;
            $display("FAIL up_count edge=%0d got %b %b %0d %0d want %b %b %0d %0d", i,
                     locked, err, expected, err_count, m_locked, m_err, m_pred, m_errcnt);
         end
         n_vec++;
         if (i == 3 || i == 4) begin
            if (locked !== (i == 4)) begin
               n_fail++;
               $display("FAIL lock_edge edge=%0d got locked=%b want %b", i, locked, (i == 4));
            end
            n_vec++;
         end
      end
   endtask

   task automatic test_down_wrap();
      load = 1'b1; data = 8'd12;
      step();
      load = 1'b0; u_d = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if ({locked, err, expected, err_count} !== {m_locked, m_err, 8'(m_pred), 8'(m_errcnt)}) begin
            n_fail++;
            $display("FAIL down_wrap step=%0d got %b %b %0d %0d want %b %b %0d %0d", i,
                     locked, err, expected, err_count, m_locked, m_err, m_pred, m_errcnt);
         end
         n_vec++;
      end
      if (expected !== 8'd39 || err !== 1'b0 || locked !== 1'b1) begin
         n_fail++;
         $display("FAIL down_wrap_end got expected=%0d err=%b locked=%b want 39 0 1",
                  expected, err, locked);
      end
      n_vec++;
   endtask

   task automatic test_inject();
      u_d = 1'b1; load = 1'b1; data = 8'd20;
      step();
      load = 1'b0;
      step();
      count_in = 8'd25;
      step();
`ifdef COUNT_RANGE_CHECKER_ERRCNT_EN
      if (err !== 1'b1 || locked !== 1'b0 || err_count !== 8'd1) begin
`else
      if (err !== 1'b1 || locked !== 1'b0 || err_count !== 8'd0) begin
`endif
         n_fail++;
         $display("FAIL inject_err got err=%b locked=%b err_count=%0d want err=1 locked=0",
                  err, locked, err_count);
      end
      n_vec++;
      step();
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL inject_single got err=%b want 0", err);
      end
      n_vec++;
      for (int i = 0; i < 3; i++) step();
      if (locked !== 1'b1 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL relock got locked=%b err=%b want 1 0", locked, err);
      end
      n_vec++;
   endtask

   task automatic test_load_oob();
      load = 1'b1; data = 8'd50;
      step();
      if (expected !== 8'd50 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL load_oob got expected=%0d err=%b want 50 0", expected, err);
      end
      n_vec++;
      load = 1'b0;
      step();
      if (expected !== 8'd10 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL load_oob_next got expected=%0d err=%b want 10 0", expected, err);
      end
      n_vec++;
      step();
      if (err !== 1'b0 || locked !== 1'b1) begin
         n_fail++;
         $display("FAIL load_oob_wrap got err=%b locked=%b want 0 1", err, locked);
      end
      n_vec++;
   endtask

   task automatic test_cnt_rst_and_rst();
      load = 1'b1; data = 8'd33;
      step();
      load = 1'b0; cnt_rst = 1'b0;
      step();
      if (expected !== 8'd10 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL cnt_rst got expected=%0d err=%b want 10 0", expected, err);
      end
      n_vec++;
      cnt_rst = 1'b1;
      step();
      count_in = 8'(m_pred + 1);
      step();
      step();
      step();
      if (locked !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_acquire got locked=%b want 0", locked);
      end
      n_vec++;
      rst = 1'b0;
      step();
      if (locked !== 1'b0 || err !== 1'b0 || expected !== 8'd10 || err_count !== 8'd0) begin
         n_fail++;
         $display("FAIL rst_mid_acquire got %b %b %0d %0d want 0 0 10 0",
                  locked, err, expected, err_count);
      end
      n_vec++;
      rst = 1'b1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         cnt_rst = ($urandom % 16) != 0;
         load    = ($urandom % 8) == 0;
         data    = 8'($urandom_range(0, 60));
         u_d     = 1'($urandom);
         if (($urandom % 10) == 0) count_in = 8'($urandom);
         step();
         if ({locked, err, expected, err_count} !== {m_locked, m_err, 8'(m_pred), 8'(m_errcnt)}) begin
            n_fail++;
            $display("FAIL random cyc=%0d got %b %b %0d %0d want %b %b %0d %0d", i,
                     locked, err, expected, err_count, m_locked, m_err, m_pred, m_errcnt);
         end
         n_vec++;
      end
      cnt_rst = 1'b1; load = 1'b0; u_d = 1'b1;
   endtask

   task automatic test_saturate();
      for (int k = 0; k < 300; k++) begin
         for (int i = 0; i < 6; i++) begin
            if (i == 5) count_in = 8'(m_pred + 1);
            step();
            if ({locked, err, expected, err_count} !== {m_locked, m_err, 8'(m_pred), 8'(m_errcnt)}) begin
               n_fail++;
               $display("FAIL saturate k=%0d i=%0d got %b %b %0d %0d want %b %b %0d %0d", k, i,
                        locked, err, expected, err_count, m_locked, m_err, m_pred, m_errcnt);
            end
            n_vec++;
         end
      end
`ifdef COUNT_RANGE_CHECKER_ERRCNT_EN
      if (err_count !== 8'd255) begin
         n_fail++;
         $display("FAIL saturate_final got err_count=%0d want 255", err_count);
      end
`else
      if (err_count !== 8'd0) begin
         n_fail++;
         $display("FAIL errcnt_disabled got err_count=%0d want 0", err_count);
      end
`endif
      n_vec++;
   endtask

   initial begin
      test_reset();
      test_up_count();
      test_down_wrap();
      test_inject();
      test_load_oob();
      test_cnt_rst_and_rst();
      test_random();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/count_range_checker.md
# count_range_checker

Passive sequence monitor for the 8-bit up/down modulus-range counter (range MIN..MAX, default 10..40). It observes the counter's output and control inputs, predicts every next count with a reference model, and locks after consecutive correct predictions. Once locked it flags deviations and counts them. It sits beside the counter in the datapath and in the bench as its receiving end; it never drives the counter.

## Interface
- WIDTH, 8: count/data width.
- MIN, 10: lower range bound (inclusive).
- MAX, 40: upper range bound (inclusive); MIN < MAX required.
- LOCK_CNT, 3: consecutive matches needed to enter LOCKED (1..15).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low; clock clk.
- cnt_rst  in  1  observed counter reset (active-low), same cycle as the counter sees it.
- load  in  1  observed counter load.
- data  in  WIDTH  observed counter load data.
- u_d  in  1  observed direction (1 = up).
- count_in  in  WIDTH  observed counter output.
- locked  out  1  prediction tracking established.
- err  out  1  one-cycle pulse: mismatch while LOCKED.
- expected  out  WIDTH  prediction for the next count_in.
- err_count  out  8  saturating mismatch count (see Configuration).

## Operation
- The reference model f(c, cnt_rst, load, data, u_d) gives the next count from the current observed count c and the controls:
  - MIN if !cnt_rst, c > MAX, or c < MIN;
  - otherwise data if load;
  - otherwise, if u_d: MIN when c >= MAX, else c+1;
  - otherwise (down): MAX when c <= MIN, else c−1.
- Every edge: pred_q <= f(count_in, controls). The model always re-seeds from the observed count_in, never from pred_q, so one fault produces one error only.
- All arithmetic is WIDTH bits with unsigned compares. Load data outside the range is legal. The model then predicts data, and the cycle after that predicts MIN.
- FSM states: IDLE, ACQUIRE, LOCKED. match = (count_in == pred_q).
  - IDLE → ACQUIRE unconditionally on the first edge after reset. pred_q is not yet valid, so no compare is made.
  - ACQUIRE: on match, increment match_cnt; at LOCK_CNT go to LOCKED. On mismatch, clear match_cnt and stay. No err in this state.
  - LOCKED: on match, stay. On mismatch, pulse err, increment err_count, clear match_cnt, go to ACQUIRE (locked drops).
- expected = pred_q.

## Timing
- Reset (rst low at an edge): state IDLE, locked 0, err 0, err_count 0, expected = MIN, match_cnt 0. rst has priority over everything, including mid-acquire and mid-error.
- Compare latency: a bad count_in that is present before edge k produces err=1 during cycle k→k+1. err is registered and lasts exactly one cycle.
- locked rises on the same edge that records the LOCK_CNT-th match. From the first edge after reset release, that is edge 1+LOCK_CNT at the earliest.
- Simultaneous cnt_rst and load: cnt_rst wins (predict MIN). Simultaneous load and wrap: load wins.
- Mismatch on the edge that would complete locking: no lock, and match_cnt goes to 0.

## Configuration
- COUNT_RANGE_CHECKER_ERRCNT_EN defined: err_count is an 8-bit saturating counter that holds at 255 and is cleared only by rst.
- Not defined: no err_count register exists; the err_count port is tied to 0. err and locked are unaffected.

## Structure
- Package count_chk_pkg holds:
  - the state enum (IDLE, ACQUIRE, LOCKED);
  - default MIN/MAX/WIDTH constants;
  - the pure function next_count implementing f.
- Sub-module count_range_model: a combinational wrapper around next_count. It is reused by the counter's bench scoreboard.
- The top holds pred_q, the FSM, match_cnt, and err_count.

## Test plan
- Reset, then up-count 10..40 with u_d=1 and no errors: locked=1 after edge 4 (LOCK_CNT=3); count 40→10 wraps with err=0.
- Locked, down-count 12,11,10,40: wrap accepted, err stays 0, expected=39 after 40 is observed.
- Locked, inject count_in=25 where 21 is expected: exactly one err pulse the next cycle, err_count=1, locked=0, relock after 3 good cycles.
- load=1 with data=50 while locked: expected=50; the next cycle expects 10; the counter's 50→10 produces no error.
- cnt_rst=0 at count 33: expected=10 and no error. Then rst=0 mid-ACQUIRE: all outputs return to reset values on that edge.
- With ERRCNT_EN, force 300 mismatches: err_count saturates at 255. Without the macro, err_count stays 0 throughout.
